interval_timer_ctrl: RTL
========================

# interval_timer_ctrl

Programmable interval timer controller that sequences a 16-bit up-counter datapath: it starts, stops, restarts and wraps the count against a software-loaded period and raises a level interrupt with an acknowledge handshake. It sits between the control/register logic and the counter datapath. It supports one-shot and periodic modes, plus an optional clock prescaler.

## Interface
- WIDTH, 16, counter and period width
- PRESC_W, 8, prescaler width (used only when the prescaler is compiled in)

- clk  in  1  rising-edge clock
- rst_async  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: load period/mode and (re)start counting
- stop  in  1  single-cycle pulse: abort counting
- mode_periodic  in  1  sampled on start: 1 = periodic, 0 = one-shot
- period  in  WIDTH  sampled on start: interval in ticks; 0 = illegal
- presc  in  PRESC_W  sampled on start: tick every presc+1 clocks
- irq_ack  in  1  clears irq
- count  out  WIDTH  current count
- busy  out  1  high in RUN
- irq  out  1  level interrupt, held until acknowledged
- overrun  out  1  sticky: a match occurred while irq was still set

## Operation
- States: IDLE, RUN, DONE. Reset values: state = IDLE, count = 0, busy = 0, irq = 0, overrun = 0, prescaler = 0.
- start latches period_q, mode_q and presc_q.
  - If period = 0: start is ignored and state is unchanged.
  - Otherwise: count ← 0, prescaler ← 0, overrun ← 0, and the state moves to RUN.
- start is accepted from any state. Issued in RUN, it restarts the timer.
- tick:
  - With the prescaler compiled in, tick is asserted when prescaler = presc_q; the prescaler then wraps to 0, otherwise it increments.
  - Without the prescaler, tick = 1 every cycle in RUN.
- RUN, on tick with count ≠ period_q−1: count ← count+1.
- RUN, on tick with count = period_q−1 (match):
  - irq ← 1.
  - If irq is already 1 and irq_ack is 0 in the same cycle: overrun ← 1.
  - Periodic mode: count ← 0, stay in RUN.
  - One-shot mode: count holds at period_q−1, go to DONE.
- DONE: busy = 0, count frozen. Leaves to IDLE in the cycle irq_ack is sampled high.
- stop in RUN goes to IDLE with count frozen. irq and overrun are unchanged. stop in IDLE or DONE has no effect.
- Simultaneous events:
  - start and stop in the same cycle: stop wins; start is discarded.
  - irq_ack and match in the same cycle: irq stays 1 and no overrun is recorded.
  - irq_ack with no match: irq ← 0 at the next edge.
- count never exceeds period_q−1, and it wraps only through the match path.
- All arithmetic is modulo 2^WIDTH; no carry out is exposed.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.

## Timing
- All outputs are registered.
- If start is sampled at edge N: count = 0 and busy = 1 after edge N.
- With presc = 0, count increments at edges N+1 … N+period−1, and irq rises at edge N+period.
- The interval between periodic irq assertions is period × (presc+1) clocks.
- irq falls one edge after irq_ack is sampled, unless a coincident match occurs.
- One-shot: busy falls at the same edge irq rises.
- There is no combinational path from inputs to outputs.

## Configuration
- TIMER_PRESCALE_EN
  - Defined: presc port and PRESC_W prescaler counter are present; tick period is presc+1 clocks.
  - Undefined: the presc port is still present but ignored, the prescaler logic is removed, and tick = 1 every RUN cycle.

## Structure
- Shared package timer_pkg: state enum (IDLE, RUN, DONE), WIDTH/PRESC_W default constants.
- One sub-module, timer_count_core. It is the WIDTH-bit counter with clear and enable inputs, driven by the FSM's clear, enable (tick) and hold controls.
- Prescaler and FSM live in interval_timer_ctrl.

## Test plan
- Reset mid-RUN (period = 10, count = 4): count = 0, busy = 0, irq = 0, overrun = 0 immediately, without waiting for a clock edge. After release, the block stays in IDLE until start.
- Periodic, period = 5, presc = 0, irq_ack pulsed one cycle after each irq: irq rises at N+5, N+10, N+15; count sequence 0,1,2,3,4,0,…; overrun stays 0.
- One-shot, period = 3:
  - irq and busy↓ at N+3; count holds 2.
  - irq_ack at N+6 → IDLE, irq = 0 at N+7.
  - A second start → count = 0, busy = 1.
- Periodic, period = 2, never acknowledged: overrun = 1 at N+4 and stays 1 until the next start.
- start with stop in the same cycle → remains IDLE. start with period = 0 → ignored. start in RUN at count = 7 → count = 0 next edge.
- TIMER_PRESCALE_EN defined, presc = 3, period = 4: irq at N+16; count increments every 4 clocks.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and default sizes for the interval timer controller.
package timer_pkg;

    localparam int unsigned TIMER_WIDTH   = 16;
    localparam int unsigned TIMER_PRESC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between the register logic (master) and the timer (slave).
interface interval_timer_ctrl_if #(
    parameter int WIDTH   = timer_pkg::TIMER_WIDTH,
    parameter int PRESC_W = timer_pkg::TIMER_PRESC_W
);
    logic               start;
    logic               stop;
    logic               mode_periodic;
    logic [WIDTH-1:0]   period;
    logic [PRESC_W-1:0] presc;
    logic               irq_ack;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               irq;
    logic               overrun;

    modport master (
        output start, stop, mode_periodic, period, presc, irq_ack,
        input  count, busy, irq, overrun
    );

    modport slave (
        input  start, stop, mode_periodic, period, presc, irq_ack,
        output count, busy, irq, overrun
    );
endinterface

// File: rtl/timer_count_core.sv
// WIDTH-bit up-counter: clear has priority, hold freezes, enable advances by one.
module timer_count_core #(
    parameter int WIDTH = timer_pkg::TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             clear,
    input  logic             enable,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !hold) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer FSM and optional prescaler driving timer_count_core.
// Optional feature: define TIMER_PRESCALE_EN to compile in the presc+1 tick divider.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH   = TIMER_WIDTH,
    parameter int PRESC_W = TIMER_PRESC_W
) (
    input logic                  clk,
    input logic                  rst_async,
    interval_timer_ctrl_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] last_count;
    logic             mode_q;
    logic             busy_q;
    logic             irq_q;
    logic             overrun_q;

    logic start_ok;
    logic run_go;
    logic tick;
    logic match;
    logic cnt_clear;
    logic cnt_enable;
    logic cnt_hold;

    // A start coinciding with stop, or carrying a zero period, is discarded.
    assign start_ok   = bus.start && !bus.stop && (bus.period != '0);
    assign run_go     = (state == RUN) && !bus.stop && !start_ok;
    assign last_count = period_q - 1'b1;
    assign match      = run_go && tick && (count == last_count);

    assign cnt_clear  = start_ok || (match && mode_q);
    assign cnt_enable = run_go && tick && !match;
    assign cnt_hold   = (state != RUN) || bus.stop;

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt;

    assign tick = (state == RUN) && (presc_cnt == presc_q);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            presc_q   <= '0;
            presc_cnt <= '0;
        end else if (start_ok) begin
            presc_q   <= bus.presc;
            presc_cnt <= '0;
        end else if (run_go) begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        end
    end
`else
    logic [PRESC_W-1:0] unused_presc;

    assign unused_presc = bus.presc;
    assign tick         = (state == RUN);
`endif

    timer_count_core #(.WIDTH(WIDTH)) u_count_core (
        .clk       (clk),
        .rst_async (rst_async),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .hold      (cnt_hold),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state     <= IDLE;
            period_q  <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // A match later in this block overrides the acknowledge clear.
            if (bus.irq_ack) begin
                irq_q <= 1'b0;
            end
            if (start_ok) begin
                period_q  <= bus.period;
                mode_q    <= bus.mode_periodic;
                overrun_q <= 1'b0;
                busy_q    <= 1'b1;
                state     <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.stop) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else if (match) begin
                            irq_q <= 1'b1;
                            if (irq_q && !bus.irq_ack) begin
                                overrun_q <= 1'b1;
                            end
                            if (!mode_q) begin
                                busy_q <= 1'b0;
                                state  <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (bus.irq_ack) begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.count   = count;
    assign bus.busy    = busy_q;
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;

endmodule
